// File: rtl/tone_decoder_if.sv
// ---------------------------------------------------------------------------
// tone_decoder_if
// Bundles the tone input pin and the decoded-tone status outputs of the
// tone decoder into one interface.
//
//   tone_in   : square-wave tone input. It may be asynchronous to clk.
//   tone_code : 0 = none/lost, 1..6 = decoded tone.
//   valid     : high while tone_code is in 1..6.
//   changed   : one-cycle pulse on every tone_code transition.
//   led       : active-low one-hot LED pattern (code k in 1..5 -> bit k-1 low).
//
// Modports:
//   master : the side that drives the tone pin and reads the status
//            (the surrounding system or a testbench).
//   slave  : the decoder itself.
// ---------------------------------------------------------------------------
interface tone_decoder_if;
  logic       tone_in;
  logic [2:0] tone_code;
  logic       valid;
  logic       changed;
  logic [4:0] led;

  modport master (
    output tone_in,
    input  tone_code,
    input  valid,
    input  changed,
    input  led
  );

  modport slave (
    input  tone_in,
    output tone_code,
    output valid,
    output changed,
    output led
  );
endinterface

// File: rtl/tone_decoder.sv
// ---------------------------------------------------------------------------
// tone_decoder
// Receive end of the key-selected buzzer tone link. The block measures the
// time between successive edges of the incoming square wave (the half-period,
// H). It classifies each H against the six tone windows. When MATCH_N
// consecutive half-periods agree, it reports the matching tone.
//
// Tone k (k = 1..6) has a nominal half-period of H_k = k*BASE+1 clocks.
// A measurement belongs to class k when |H - H_k| <= TOL. Any other value
// belongs to class 7 (invalid).
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : tone_decoder_if.slave. It carries tone_in (input) and
//           tone_code / valid / changed / led (outputs).
//
// Timing: an edge on tone_in becomes visible 2-3 clocks later as cycle E,
// the cycle in which the synchronised level differs from its delayed copy.
// H is latched at the end of E. It is classified, and the run and decision
// logic is updated, at the end of E+1. The outputs are therefore visible
// from E+2.
// ---------------------------------------------------------------------------
module tone_decoder #(
  parameter int BASE    = 100_000,
  parameter int TOL     = 1_000,
  parameter int MATCH_N = 4,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  tone_decoder_if.slave  bus
);

  localparam int             RUN_W   = $clog2(MATCH_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MATCH_N);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [31:0]    CNT_MAX = 32'(TIMEOUT);
  localparam logic [2:0]     CLS_BAD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,    // no reference edge seen since reset/timeout
    ST_ARMED,   // primed, waiting for the first measurement
    ST_TRACK,   // measuring, no tone currently reported
    ST_LOCKED   // measuring with a valid tone reported
  } state_t;

  // Synchroniser and edge detection
  logic s1_q, s2_q, s3_q;
  logic edge_w;

  // Half-period measurement
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] h_q;
  logic        meas_q;    // h_q holds a fresh measurement this cycle
  logic        timeout_w;

  // Classification
  logic [5:0] match_w;
  logic [2:0] cls_w;

  // Decoder state
  state_t           state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic [4:0]       led_q, led_d;

  // The pin is asynchronous. s1/s2 resolve metastability. s3 is a delayed
  // copy of s2, used to detect edges of either polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.tone_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_w = s2_q ^ s3_q;

  // An edge in the same cycle as a timeout wins: the count restarts and no
  // loss is declared.
  assign timeout_w = (cnt_q == CNT_MAX) && !edge_w;

  // The counter clears on an edge. It saturates at TIMEOUT, so that a
  // stalled input keeps reporting the timeout condition and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_w) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // H = cnt+1 at the edge is the number of clocks since the previous edge.
  // The priming edge (in IDLE) updates h_q but does not raise meas_q, so its
  // value is never classified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      h_q    <= '0;
      meas_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      meas_q <= edge_w && (state_q != ST_IDLE);
      if (edge_w) begin
        h_q <= cnt_q + 32'd1;
      end
    end
  end

  // One tolerance window per tone. TOL < BASE/2, so the windows are
  // disjoint and at most one bit of match_w is set.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_win
      localparam logic [31:0] WIN_LO = 32'((gi + 1) * BASE + 1 - TOL);
      localparam logic [31:0] WIN_HI = 32'((gi + 1) * BASE + 1 + TOL);
      assign match_w[gi] = (h_q >= WIN_LO) && (h_q <= WIN_HI);
    end
  endgenerate

  always_comb begin
    cls_w = CLS_BAD;
    for (int k = 0; k < 6; k++) begin
      if (match_w[k]) begin
        cls_w = 3'(k + 1);
      end
    end
  end

  function automatic logic [4:0] led_of(input logic [2:0] code);
    logic [4:0] pat;
    case (code)
      3'd1:    pat = 5'b11110;
      3'd2:    pat = 5'b11101;
      3'd3:    pat = 5'b11011;
      3'd4:    pat = 5'b10111;
      3'd5:    pat = 5'b01111;
      default: pat = 5'b11111;  // 0 (none) and 6 (no key) light nothing
    endcase
    return pat;
  endfunction

  // Next-state, run tracking and output decision
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    run_d     = run_q;
    code_d    = code_q;
    valid_d   = valid_q;
    changed_d = 1'b0;

    if (timeout_w) begin
      // Input stalled: forget all history. The next edge only re-primes.
      state_d = ST_IDLE;
      cand_d  = 3'd0;
      run_d   = '0;
      if (valid_q) begin
        code_d    = 3'd0;
        valid_d   = 1'b0;
        changed_d = 1'b1;
      end
    end else begin
      if (edge_w && (state_q == ST_IDLE)) begin
        state_d = ST_ARMED;
      end

      if (meas_q) begin
        if (state_q == ST_ARMED) begin
          state_d = ST_TRACK;
        end

        if (cls_w == cand_q) begin
          if (run_q < RUN_MAX) begin
            run_d = run_q + 1'b1;
          end
        end else begin
          cand_d = cls_w;
          run_d  = RUN_ONE;
        end

        // The decision uses the updated run. The cand != code test stops a
        // saturated run from pulsing changed again on later edges.
        if (run_d == RUN_MAX) begin
          if ((cand_d != CLS_BAD) && (cand_d != code_q)) begin
            code_d    = cand_d;
            valid_d   = 1'b1;
            changed_d = 1'b1;
            state_d   = ST_LOCKED;
          end else if ((cand_d == CLS_BAD) && valid_q) begin
            code_d    = 3'd0;
            valid_d   = 1'b0;
            changed_d = 1'b1;
            state_d   = ST_TRACK;
          end
        end
      end
    end

    // led follows the next code, so it switches in the same cycle as
    // tone_code.
    led_d = led_of(code_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cand_q    <= 3'd0;
      run_q     <= '0;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      led_q     <= 5'b11111;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      run_q     <= run_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      led_q     <= led_d;
    end
  end

  assign bus.tone_code = code_q;
  assign bus.valid     = valid_q;
  assign bus.changed   = changed_q;
  assign bus.led       = led_q;

endmodule

// File: tb/tb_tone_decoder.sv
// ---------------------------------------------------------------------------
// tb_tone_decoder
// Drives square waves with chosen half-periods into tone_decoder. Each output
// is compared with a reference model that works on whole half-periods: every
// measurement after the priming edge is classified. The reported tone changes
// whenever the last MATCH_N classes are identical.
// ---------------------------------------------------------------------------
module tb_tone_decoder;
  localparam int BASE    = 100;
  localparam int TOL     = 5;
  localparam int MATCH_N = 4;
  localparam int TIMEOUT = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tone_decoder_if bus ();

  tone_decoder #(
    .BASE    (BASE),
    .TOL     (TOL),
    .MATCH_N (MATCH_N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Counters for checks and passes
  int checks = 0;
  int passed = 0;

  // Reference model state
  int  exp_code = 0;
  int  exp_chg  = 0;
  bit  primed   = 1'b0;
  int  win[$];
  int  prev_h   = 0;
  int  n_edges  = 0;

  // Observation of the changed pulses
  int  chg_seen = 0;
  int  b2b      = 0;
  bit  last_chg = 1'b0;

  // Storage for the random stimulus
  int kind, nrep, hh;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, want);
      $error("check %s", tag);
    end
  endtask

  function automatic int classify(input int h);
    int c;
    c = 7;
    for (int k = 1; k <= 6; k++) begin
      if (h >= k * BASE + 1 - TOL && h <= k * BASE + 1 + TOL) c = k;
    end
    return c;
  endfunction

  function automatic logic [4:0] exp_led(input int code);
    logic [4:0] t;
    case (code)
      1: t = 5'b11110;
      2: t = 5'b11101;
      3: t = 5'b11011;
      4: t = 5'b10111;
      5: t = 5'b01111;
      default: t = 5'b11111;
    endcase
    return t;
  endfunction

  task automatic model_measure(input int h);
    int c;
    bit same;
    c = classify(h);
    win.push_back(c);
    if (win.size() > MATCH_N) void'(win.pop_front());
    if (win.size() == MATCH_N) begin
      same = 1'b1;
      foreach (win[i]) if (win[i] != c) same = 1'b0;
      if (same) begin
        if (c <= 6 && c != exp_code) begin
          exp_code = c;
          exp_chg++;
        end else if (c == 7 && exp_code != 0) begin
          exp_code = 0;
          exp_chg++;
        end
      end
    end
  endtask

  task automatic model_edge();
    if (!primed) begin
      primed = 1'b1;
      win.delete();
    end else begin
      model_measure(prev_h);
    end
  endtask

  task automatic model_clear();
    primed = 1'b0;
    win.delete();
    if (exp_code != 0) begin
      exp_code = 0;
      exp_chg++;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.changed) begin
        chg_seen++;
        if (last_chg) b2b++;
      end
      last_chg = bus.changed;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_code"},  32'(bus.tone_code), 32'(exp_code));
    check({tag, "_valid"}, 32'(bus.valid),     32'(exp_code != 0));
    check({tag, "_led"},   32'(bus.led),       32'(exp_led(exp_code)));
    check({tag, "_nchg"},  32'(chg_seen),      32'(exp_chg));
  endtask

  // Toggle now: this edge ends the previous half-period. Then hold for h
  // clocks, with the outputs checked once the decision has settled.
  task automatic run_half(input int h);
    bus.tone_in = ~bus.tone_in;
    model_edge();
    prev_h = h;
    n_edges++;
    tick(8);
    $display("edge %0d: meas %0d -> code %0d valid %0b led %05b", n_edges,
             primed ? prev_h : 0, bus.tone_code, bus.valid, bus.led);
    check_outputs("edge");
    tick(h - 8);
  endtask

  // Last edge, then silence until the decoder declares the tone lost.
  task automatic run_loss();
    bus.tone_in = ~bus.tone_in;
    model_edge();
    n_edges++;
    tick(8);
    check_outputs("last_edge");
    tick(1995 - 8);
    check_outputs("pre_timeout");
    tick(15);
    model_clear();
    $display("timeout: code %0d valid %0b led %05b", bus.tone_code, bus.valid, bus.led);
    check_outputs("timeout");
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.tone_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code",    32'(bus.tone_code), 32'd0);
    check("rst_valid",   32'(bus.valid),     32'd0);
    check("rst_changed", 32'(bus.changed),   32'd0);
    check("rst_led",     32'(bus.led),       32'h1f);
    rst_n = 1'b1;
    tick(5);

    // Steady tone 3 from reset: reported after the 5th edge
    for (int i = 0; i < 5; i++) run_half(301);
    check("steady_code", 32'(bus.tone_code), 32'd3);
    check("steady_led",  32'(bus.led),       32'h1b);
    check("steady_nchg", 32'(chg_seen),      32'd1);
    for (int i = 0; i < 3; i++) run_half(301);

    // Switch to tone 5
    for (int i = 0; i < 6; i++) run_half(501);
    check("switch_led", 32'(bus.led), 32'h0f);

    // Jitter around tone 2, with one out-of-window measurement
    for (int i = 0; i < 6; i++) run_half((i % 2 == 0) ? 196 : 205);
    run_half(207);
    for (int i = 0; i < 6; i++) run_half((i % 2 == 0) ? 196 : 205);

    // Invalid tone while locked on code 3
    for (int i = 0; i < 5; i++) run_half(301);
    for (int i = 0; i < 5; i++) run_half(350);

    // Lock on tone 6, then lose it
    for (int i = 0; i < 6; i++) run_half(601);
    run_loss();

    // Resume at tone 1: the first edge only primes
    for (int i = 0; i < 4; i++) run_half(101);
    check("resume4_code", 32'(bus.tone_code), 32'd0);
    run_half(101);
    check("resume5_code", 32'(bus.tone_code), 32'd1);
    run_half(101);

    // Random segments of in-window and out-of-window half-periods
    for (int s = 0; s < 20; s++) begin
      kind = int'($urandom_range(0, 6));
      nrep = int'($urandom_range(1, 6));
      for (int r = 0; r < nrep; r++) begin
        if (kind == 0)
          hh = BASE * int'($urandom_range(1, 6)) + 1 + int'($urandom_range(10, 89));
        else
          hh = kind * BASE + 1 + int'($urandom_range(0, 2 * TOL)) - TOL;
        run_half(hh);
      end
    end

    // Lock, then reset mid-measurement: reset is asynchronous
    for (int i = 0; i < 6; i++) run_half(401);
    tick(100);
    rst_n       = 1'b0;
    bus.tone_in = 1'b0;
    #1;
    check("mid_rst_code",    32'(bus.tone_code), 32'd0);
    check("mid_rst_valid",   32'(bus.valid),     32'd0);
    check("mid_rst_changed", 32'(bus.changed),   32'd0);
    check("mid_rst_led",     32'(bus.led),       32'h1f);
    exp_code = 0;
    primed   = 1'b0;
    win.delete();
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    last_chg = 1'b0;
    tick(5);

    // History discarded: MATCH_N+1 edges needed again
    for (int i = 0; i < 6; i++) run_half(201);

    check("no_back_to_back_changed", 32'(b2b), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
